// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory stage of an in-order pipeline. It takes one EX/MEM operation at a
// time and does one of the following:
//   - Non-memory op: the ALU result goes to the writeback outputs one cycle
//     later.
//   - Load or store: the op is latched and a single-beat request goes to the
//     data memory. Upstream is frozen until the memory acks. Loads write back
//     the lane-selected and extended data in the cycle after the ack.
//
// Optional build macro:
//   MISALIGN_TRAP_EN
//     Defined:   a misaligned half/word access makes no memory request. It
//                pulses o_misalign for one cycle instead.
//     Undefined: o_misalign is tied low. The address bits below the access
//                width are forced to zero, so the access becomes aligned.
//
// Ports
//   i_clk          sole clock; all state updates on the rising edge
//   i_rst          synchronous, active-high reset
//   i_valid        EX/MEM op present
//   i_load         op is a load
//   i_store        op is a store
//   i_funct3       access width / sign (RISC-V funct3)
//   i_addr         ALU result: the address, or the result of a non-memory op
//   i_wdata        forwarded store data
//   i_rd_addr      destination register
//   o_mem_req      memory request, held high until the ack cycle
//   o_mem_we       write enable (store)
//   o_mem_addr     word-aligned memory address
//   o_mem_wdata    store data, replicated into all byte lanes
//   o_mem_bmask    byte-lane enables (4'b1111 for loads)
//   i_mem_ack      memory has completed the access
//   i_mem_rdata    memory read data (full word)
//   o_stall        freeze upstream
//   o_wb_valid     single-cycle writeback strobe
//   o_wb_rd_addr   writeback destination register
//   o_wb_data      writeback data
//   o_misalign     single-cycle misaligned-access pulse (trap build only)
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd_addr,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd_addr,
    output logic [31:0] o_wb_data,
    output logic        o_misalign
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Access width. For loads, funct3[2] only selects signedness, and the
    // 011/110/111 encodings fall through to a word access. For stores, any
    // encoding other than SB/SH is a word store.
    function automatic logic [1:0] access_size(input logic       is_load,
                                               input logic [2:0] f3);
        logic [1:0] sz;
        if (is_load) begin
            case (f3[1:0])
                2'b00:   sz = SZ_B;
                2'b01:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                3'b000:  sz = SZ_B;
                3'b001:  sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction
`else
    // Clear the address bits below the access width. The resulting access
    // is always naturally aligned.
    function automatic logic [31:0] align_addr(input logic [1:0]  sz,
                                               input logic [31:0] a);
        logic [31:0] r;
        case (sz)
            SZ_H:    r = {a[31:1], 1'b0};
            SZ_W:    r = {a[31:2], 2'b00};
            default: r = a;
        endcase
        return r;
    endfunction
`endif

    function automatic logic [3:0] lane_mask(input logic       is_load,
                                             input logic [1:0] sz,
                                             input logic [1:0] lo);
        logic [3:0] m;
        if (is_load) begin
            m = 4'b1111;
        end else begin
            case (sz)
                SZ_B:    m = 4'b0001 << lo;
                SZ_H:    m = 4'b0011 << {lo[1], 1'b0};
                default: m = 4'b1111;
            endcase
        end
        return m;
    endfunction

    // Replicate the store data so that every enabled lane sees the right
    // bytes, whatever the address offset.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  sz,
                                               input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Select the addressed lane and extend it to 32 bits.
    // A half access always has lo[0] == 0 by the time it gets here.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}},  sh[7:0]};
            3'b100:  r = {24'd0,        sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b101:  r = {16'd0,        sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Stage p0: decode of the incoming EX/MEM op (combinational)
    // -------------------------------------------------------------------------
    logic        is_mem_p0;
    logic [1:0]  size_p0;
    logic [31:0] eff_addr_p0;
    logic        trap_p0;
    logic        take_mem_p0;
    logic        take_alu_p0;

    assign is_mem_p0 = i_load | i_store;
    assign size_p0   = access_size(i_load, i_funct3);

`ifdef MISALIGN_TRAP_EN
    assign trap_p0     = i_valid & is_mem_p0 & is_misaligned(size_p0, i_addr[1:0]);
    assign eff_addr_p0 = i_addr;
`else
    assign trap_p0     = 1'b0;
    assign eff_addr_p0 = align_addr(size_p0, i_addr);
`endif

    // These are only meaningful while IDLE. The FSM and the registers below
    // qualify them with the state.
    assign take_mem_p0 = i_valid & is_mem_p0 & ~trap_p0;
    assign take_alu_p0 = i_valid & ~is_mem_p0;

    // -------------------------------------------------------------------------
    // FSM next state and stall
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        o_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (take_mem_p0) begin
                    state_d = BUSY;
                    o_stall = 1'b1;
                end
            end
            BUSY: begin
                o_stall = ~i_mem_ack;
                if (i_mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Stage p1: latched memory op, driven to the memory while BUSY
    // -------------------------------------------------------------------------
    logic        ld_p1;
    logic        st_p1;
    logic [2:0]  f3_p1;
    logic [31:0] addr_p1;
    logic [31:0] wdata_p1;
    logic [3:0]  bmask_p1;
    logic [4:0]  rd_p1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            ld_p1        <= 1'b0;
            st_p1        <= 1'b0;
            f3_p1        <= 3'd0;
            addr_p1      <= 32'd0;
            wdata_p1     <= 32'd0;
            bmask_p1     <= 4'd0;
            rd_p1        <= 5'd0;
            o_wb_valid   <= 1'b0;
            o_wb_data    <= 32'd0;
            o_wb_rd_addr <= 5'd0;
        end else begin
            state_q    <= state_d;
            o_wb_valid <= 1'b0;

            if (state_q == IDLE) begin
                if (take_mem_p0) begin
                    // A load takes priority if both flags are ever set.
                    ld_p1    <= i_load;
                    st_p1    <= i_store & ~i_load;
                    f3_p1    <= i_funct3;
                    addr_p1  <= eff_addr_p0;
                    wdata_p1 <= lane_wdata(size_p0, i_wdata);
                    bmask_p1 <= lane_mask(i_load, size_p0, eff_addr_p0[1:0]);
                    rd_p1    <= i_rd_addr;
                end
                if (take_alu_p0) begin
                    o_wb_valid   <= 1'b1;
                    o_wb_data    <= i_addr;
                    o_wb_rd_addr <= i_rd_addr;
                end
            end else if (i_mem_ack && ld_p1) begin
                o_wb_valid   <= 1'b1;
                o_wb_data    <= load_extract(f3_p1, addr_p1[1:0], i_mem_rdata);
                o_wb_rd_addr <= rd_p1;
            end
        end
    end

    assign o_mem_req   = (state_q == BUSY);
    assign o_mem_we    = st_p1;
    assign o_mem_addr  = {addr_p1[31:2], 2'b00};
    assign o_mem_wdata = wdata_p1;
    assign o_mem_bmask = bmask_p1;

`ifdef MISALIGN_TRAP_EN
    logic misalign_p1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            misalign_p1 <= 1'b0;
        end else begin
            misalign_p1 <= (state_q == IDLE) & trap_p0;
        end
    end

    assign o_misalign = misalign_p1;
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage. It runs directed scenarios and then
// randomized operations. A byte-level reference model predicts the memory
// request and the writeback result of each op.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_load;
    logic        i_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [4:0]  i_rd_addr;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_stall;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd_addr;
    logic [31:0] o_wb_data;
    logic        o_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_load       (i_load),
        .i_store      (i_store),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_rd_addr    (i_rd_addr),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_stall      (o_stall),
        .o_wb_valid   (o_wb_valid),
        .o_wb_rd_addr (o_wb_rd_addr),
        .o_wb_data    (o_wb_data),
        .o_misalign   (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    // Observations captured by run_op
    logic        ob_stall0;
    int          ob_stall_cycles;
    int          ob_req_cycles;
    logic        ob_unstable;
    logic [31:0] ob_addr;
    logic        ob_we;
    logic [3:0]  ob_bmask;
    logic [31:0] ob_wdata;
    logic        ob_wbv;
    logic [31:0] ob_wbd;
    logic [4:0]  ob_wbrd;
    logic        ob_mis;
    logic        ob_req_after;
    logic        ob_wbv_after;
    logic        ob_mis_after;

    // Model predictions
    logic        exp_mem;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_bmask;
    logic [31:0] exp_wdata;
    logic        exp_wbv;
    logic [31:0] exp_wbd;
    logic [4:0]  exp_wbrd;
    logic        exp_mis;

    // Reference model. It works on the memory as four byte lanes and on the
    // access as (offset, size in bytes).
    task automatic model_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [31:0] rdata);
        int          size;
        int          off;
        logic [31:0] ea;
        longint      v;
        logic        sgn;
        exp_mem   = 1'b0;
        exp_addr  = 32'd0;
        exp_we    = 1'b0;
        exp_bmask = 4'd0;
        exp_wdata = 32'd0;
        exp_wbv   = 1'b0;
        exp_wbd   = 32'd0;
        exp_wbrd  = 5'd0;
        exp_mis   = 1'b0;
        if (!ld && !st) begin
            exp_wbv  = 1'b1;
            exp_wbd  = addr;
            exp_wbrd = rd;
            return;
        end
        if (ld) size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        else    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        if ((addr % size) != 0) begin
            exp_mis = 1'b1;
            return;
        end
`endif
        ea       = addr - (addr % size);
        off      = int'(ea % 4);
        exp_mem  = 1'b1;
        exp_we   = st && !ld;
        exp_addr = ea & ~32'd3;
        for (int i = 0; i < 4; i++) begin
            if (ld || (i >= off && i < off + size)) exp_bmask[i] = 1'b1;
            exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        if (ld) begin
            v = 0;
            for (int j = 0; j < size; j++)
                v = v | (longint'(rdata[8*(off+j) +: 8]) << (8*j));
            sgn = (f3 == 3'd0 || f3 == 3'd1);
            if (size < 4 && sgn && v >= (longint'(1) << (8*size-1)))
                v = v - (longint'(1) << (8*size));
            exp_wbv  = 1'b1;
            exp_wbd  = v[31:0];
            exp_wbrd = rd;
        end
    endtask

    // Drives one op from acceptance to completion. The memory acks in the
    // ack_wait-th BUSY cycle, counting from 0. If scramble is set, the op
    // inputs change during BUSY; the DUT must ignore them.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int ack_wait,
                          input logic [31:0] rdata, input logic scramble);
        i_valid   = 1'b1;
        i_load    = ld;
        i_store   = st;
        i_funct3  = f3;
        i_addr    = addr;
        i_wdata   = wd;
        i_rd_addr = rd;
        i_mem_ack = 1'b0;
        #1;
        ob_stall0       = o_stall;
        ob_stall_cycles = o_stall ? 1 : 0;
        ob_req_cycles   = o_mem_req ? 1 : 0;
        ob_unstable     = 1'b0;
        ob_addr  = 32'd0; ob_we = 1'b0; ob_bmask = 4'd0; ob_wdata = 32'd0;
        @(posedge i_clk); #1;
        if (ob_stall0) begin
            for (int k = 0; k <= ack_wait; k++) begin
                if (scramble) begin
                    i_addr    = $urandom;
                    i_wdata   = $urandom;
                    i_funct3  = 3'($urandom);
                    i_rd_addr = 5'($urandom);
                end
                if (k == ack_wait) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rdata;
                end else begin
                    i_mem_rdata = $urandom;
                end
                #1;
                if (o_mem_req) ob_req_cycles++;
                if (o_stall) ob_stall_cycles++;
                if (k == 0) begin
                    ob_addr = o_mem_addr; ob_we = o_mem_we;
                    ob_bmask = o_mem_bmask; ob_wdata = o_mem_wdata;
                end else if (ob_addr !== o_mem_addr || ob_we !== o_mem_we ||
                             ob_bmask !== o_mem_bmask || ob_wdata !== o_mem_wdata) begin
                    ob_unstable = 1'b1;
                end
                @(posedge i_clk); #1;
            end
            i_mem_ack = 1'b0;
        end
        i_valid = 1'b0;
        i_load  = 1'b0;
        i_store = 1'b0;
        ob_wbv       = o_wb_valid;
        ob_wbd       = o_wb_data;
        ob_wbrd      = o_wb_rd_addr;
        ob_mis       = o_misalign;
        ob_req_after = o_mem_req;
        @(posedge i_clk); #1;
        ob_wbv_after = o_wb_valid;
        ob_mis_after = o_misalign;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0;
        i_funct3 = 3'd2; i_addr = 32'h100; i_wdata = $urandom; i_rd_addr = 5'd7;
        i_mem_ack = 1'b1; i_mem_rdata = $urandom;
        repeat (2) @(posedge i_clk);
        #1;
        n_tests++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
        n_tests++; if (o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wbv: got %b want 0", o_wb_valid); end
        n_tests++; if (o_wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wbd: got %h want 0", o_wb_data); end
        n_tests++; if (o_wb_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wbrd: got %h want 0", o_wb_rd_addr); end
        n_tests++; if (o_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", o_misalign); end
        i_rst = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_mem_ack = 1'b0;
        #1;
        n_tests++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_stall); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_alu_op();
        run_op(1'b0, 1'b0, 3'd0, 32'h0000_0055, 32'd0, 5'd3, 0, 32'd0, 1'b0);
        n_tests++; if (ob_stall0 !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", ob_stall0); end
        n_tests++; if (ob_wbv !== 1'b1) begin n_fail++; $display("FAIL alu_wbv: got %b want 1", ob_wbv); end
        n_tests++; if (ob_wbd !== 32'h55) begin n_fail++; $display("FAIL alu_wbd: got %h want 55", ob_wbd); end
        n_tests++; if (ob_wbrd !== 5'd3) begin n_fail++; $display("FAIL alu_wbrd: got %0d want 3", ob_wbrd); end
        n_tests++; if (ob_wbv_after !== 1'b0) begin n_fail++; $display("FAIL alu_wbv_pulse: got %b want 0", ob_wbv_after); end
        n_tests++; if (ob_req_after !== 1'b0) begin n_fail++; $display("FAIL alu_req: got %b want 0", ob_req_after); end
    endtask

    task automatic test_load_byte();
        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd9, 3, 32'h80FF_0000, 1'b1);
        n_tests++; if (ob_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 100", ob_addr); end
        n_tests++; if (ob_stall_cycles != 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 4", ob_stall_cycles); end
        n_tests++; if (ob_req_cycles != 4) begin n_fail++; $display("FAIL lb_req_cycles: got %0d want 4", ob_req_cycles); end
        n_tests++; if (ob_we !== 1'b0 || ob_bmask !== 4'hF) begin n_fail++; $display("FAIL lb_we_bmask: got %b/%b want 0/1111", ob_we, ob_bmask); end
        n_tests++; if (ob_wbv !== 1'b1 || ob_wbd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %b/%h want 1/ffffff80", ob_wbv, ob_wbd); end
        n_tests++; if (ob_wbrd !== 5'd9) begin n_fail++; $display("FAIL lb_rd: got %0d want 9", ob_wbrd); end
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd10, 3, 32'h80FF_0000, 1'b0);
        n_tests++; if (ob_wbv !== 1'b1 || ob_wbd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %b/%h want 1/00000080", ob_wbv, ob_wbd); end
        n_tests++; if (ob_unstable !== 1'b0) begin n_fail++; $display("FAIL lb_stable: got %b want 0", ob_unstable); end
    endtask

    task automatic test_store_half();
        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd4, 1, 32'hDEAD_BEEF, 1'b1);
        n_tests++; if (ob_stall0 !== 1'b1) begin n_fail++; $display("FAIL sh_stall0: got %b want 1", ob_stall0); end
        n_tests++; if (ob_bmask !== 4'b1100) begin n_fail++; $display("FAIL sh_bmask: got %b want 1100", ob_bmask); end
        n_tests++; if (ob_wdata !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata: got %h want abcdabcd", ob_wdata); end
        n_tests++; if (ob_we !== 1'b1 || ob_addr !== 32'h200) begin n_fail++; $display("FAIL sh_we_addr: got %b/%h want 1/200", ob_we, ob_addr); end
        n_tests++; if (ob_wbv !== 1'b0 || ob_wbv_after !== 1'b0) begin n_fail++; $display("FAIL sh_no_wb: got %b%b want 00", ob_wbv, ob_wbv_after); end
        n_tests++; if (ob_req_after !== 1'b0) begin n_fail++; $display("FAIL sh_req_drop: got %b want 0", ob_req_after); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd_word;
        rd_word = $urandom;
        run_op(1'b1, 1'b0, 3'b010, 32'h006, 32'd0, 5'd5, 0, rd_word, 1'b0);
`ifdef MISALIGN_TRAP_EN
        n_tests++; if (ob_stall0 !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", ob_stall0); end
        n_tests++; if (ob_req_after !== 1'b0 || ob_req_cycles != 0) begin n_fail++; $display("FAIL mis_req: got %b/%0d want 0/0", ob_req_after, ob_req_cycles); end
        n_tests++; if (ob_mis !== 1'b1 || ob_mis_after !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b%b want 10", ob_mis, ob_mis_after); end
        n_tests++; if (ob_wbv !== 1'b0) begin n_fail++; $display("FAIL mis_wbv: got %b want 0", ob_wbv); end
`else
        n_tests++; if (ob_addr !== 32'h004) begin n_fail++; $display("FAIL lw_mis_addr: got %h want 004", ob_addr); end
        n_tests++; if (ob_wbv !== 1'b1 || ob_wbd !== rd_word) begin n_fail++; $display("FAIL lw_mis_data: got %b/%h want 1/%h", ob_wbv, ob_wbd, rd_word); end
        n_tests++; if (ob_mis !== 1'b0 || ob_mis_after !== 1'b0) begin n_fail++; $display("FAIL lw_mis_flag: got %b%b want 00", ob_mis, ob_mis_after); end
`endif
    endtask

    task automatic test_idle_ack();
        logic bad;
        bad = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_mem_ack = 1'b1; i_mem_rdata = $urandom;
            #1;
            if (o_stall !== 1'b0 || o_mem_req !== 1'b0) bad = 1'b1;
            @(posedge i_clk); #1;
            if (o_wb_valid !== 1'b0) bad = 1'b1;
        end
        i_mem_ack = 1'b0;
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 0", bad); end
    endtask

    task automatic test_reset_busy();
        logic [31:0] w;
        i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h40; i_rd_addr = 5'd6; i_mem_ack = 1'b0;
        @(posedge i_clk); #1;          // 1st BUSY cycle
        @(posedge i_clk); #1;          // 2nd BUSY cycle
        n_tests++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_busy_req: got %b want 1", o_mem_req); end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0; i_load = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = $urandom;   // late ack
        #1;
        n_tests++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL rb_req_drop: got %b/%b want 0/0", o_mem_req, o_stall); end
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        n_tests++; if (o_wb_valid !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rb_no_wb: got %b/%b want 0/0", o_wb_valid, o_mem_req); end
        w = $urandom;
        run_op(1'b1, 1'b0, 3'b010, 32'h80, 32'd0, 5'd12, 1, w, 1'b0);
        n_tests++; if (ob_stall0 !== 1'b1 || ob_wbv !== 1'b1 || ob_wbd !== w) begin n_fail++; $display("FAIL rb_next_op: got %b/%b/%h want 1/1/%h", ob_stall0, ob_wbv, ob_wbd, w); end
    endtask

    task automatic test_random();
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata;
        logic [4:0]  rd;
        int          kind, aw;
        for (int n = 0; n < 120; n++) begin
            kind  = $urandom_range(0, 2);
            ld    = (kind == 1);
            st    = (kind == 2);
            f3    = 3'($urandom);
            addr  = $urandom;
            wd    = $urandom;
            rdata = $urandom;
            rd    = 5'($urandom);
            aw    = $urandom_range(0, 3);
            model_op(ld, st, f3, addr, wd, rd, rdata);
            run_op(ld, st, f3, addr, wd, rd, aw, rdata, 1'b1);
            n_tests++; if (ob_stall0 !== exp_mem) begin n_fail++; $display("FAIL rnd%0d_stall0: got %b want %b", n, ob_stall0, exp_mem); end
            if (exp_mem) begin
                n_tests++; if (ob_stall_cycles != aw + 1 || ob_req_cycles != aw + 1) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d/%0d want %0d", n, ob_stall_cycles, ob_req_cycles, aw + 1); end
                n_tests++; if (ob_addr !== exp_addr || ob_we !== exp_we || ob_bmask !== exp_bmask) begin n_fail++; $display("FAIL rnd%0d_req: got %h/%b/%b want %h/%b/%b", n, ob_addr, ob_we, ob_bmask, exp_addr, exp_we, exp_bmask); end
                if (st) begin
                    n_tests++; if (ob_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", n, ob_wdata, exp_wdata); end
                end
                n_tests++; if (ob_unstable !== 1'b0 || ob_req_after !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_hold: got %b/%b want 0/0", n, ob_unstable, ob_req_after); end
            end
            n_tests++; if (ob_wbv !== exp_wbv) begin n_fail++; $display("FAIL rnd%0d_wbv: got %b want %b", n, ob_wbv, exp_wbv); end
            if (exp_wbv) begin
                n_tests++; if (ob_wbd !== exp_wbd || ob_wbrd !== exp_wbrd) begin n_fail++; $display("FAIL rnd%0d_wb: got %h/%0d want %h/%0d", n, ob_wbd, ob_wbrd, exp_wbd, exp_wbrd); end
            end
            n_tests++; if (ob_mis !== exp_mis || ob_wbv_after !== 1'b0 || ob_mis_after !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_pulses: got %b/%b/%b want %b/0/0", n, ob_mis, ob_wbv_after, ob_mis_after, exp_mis); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_idle_ack();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: i_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: i_valid  in  1  EX/MEM op present; i_load  in  1; i_store  in  1; i_funct3  in  3  access width/sign.
REQ-004 SHALL have: i_addr  in  32  ALU result (alu_data_E path), i.e. the address, or the result for non-memory ops; i_wdata  in  32  forwarded store data (write_data_E path); i_rd_addr  in  5.
REQ-005 SHALL have: o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  32  word-aligned; o_mem_wdata  out  32; o_mem_bmask  out  4; i_mem_ack  in  1; i_mem_rdata  in  32.
REQ-006 SHALL have: o_stall  out  1  freeze upstream; o_wb_valid  out  1; o_wb_rd_addr  out  5; o_wb_data  out  32; o_misalign  out  1.

Function
REQ-007 SHALL implement FSM IDLE/BUSY; only IDLE accepts inputs.
REQ-008 In IDLE, i_valid with neither load nor store SHALL register o_wb_valid=1, o_wb_data=i_addr and o_wb_rd_addr=i_rd_addr next cycle (latency 1); o_stall=0.
REQ-009 In IDLE, i_valid with load or store (aligned) SHALL latch the op, go BUSY, and assert o_stall combinationally in that cycle.
REQ-010 In BUSY, o_mem_req SHALL be 1 with addr/we/wdata/bmask stable until the ack cycle; o_stall=~i_mem_ack.
REQ-011 On i_mem_ack in BUSY: -> IDLE; the next cycle, o_mem_req=0 and o_wb_valid=1 for loads (with o_wb_rd_addr = latched rd), 0 for stores; minimum load latency 2 cycles from acceptance.
REQ-012 Inputs present during BUSY SHALL be ignored (upstream holds them); i_mem_ack in IDLE SHALL be ignored.
REQ-013 o_mem_addr SHALL be {addr[31:2],2'b00}; o_mem_we=store.
REQ-014 Store bmask: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; o_mem_wdata replicates the byte (SB) or half (SH) into all lanes; loads SHALL drive bmask 4'b1111.
REQ-015 Load data SHALL select the lane by addr[1:0]: LB(000)/LH(001) sign-extend, LBU(100)/LHU(101) zero-extend, LW(010) full word; funct3 011/110/111 SHALL be treated as LW; store funct3 other than 000/001 SHALL be treated as SW.
REQ-016 o_wb_valid and o_misalign SHALL be single-cycle pulses per op.
REQ-017 Stores and loads with rd=0 SHALL complete normally; suppressing writes to x0 is left to the register file.

Reset
REQ-018 With i_rst=1 at an edge: state=IDLE, o_mem_req=0, o_wb_valid=0, o_wb_data=0, o_wb_rd_addr=0, o_misalign=0, latched op cleared.
REQ-019 Reset mid-BUSY SHALL abandon the access (o_mem_req low the cycle after the reset edge); no writeback SHALL occur for that op, and a late ack SHALL be ignored.

Configuration
REQ-020 Macro MISALIGN_TRAP_EN defined: a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no memory request, raise no stall and no writeback, and pulse o_misalign=1 the next cycle.
REQ-021 MISALIGN_TRAP_EN undefined: o_misalign SHALL be tied 0, and for misaligned accesses the low address bits below the access width SHALL be forced to 0 before lane selection.

Verification
REQ-022 Non-memory op: i_addr=0x0000_0055, rd=3 -> o_wb_valid=1, data=0x55, rd=3 one cycle later; o_stall never high.
REQ-023 LB at addr 0x103, i_mem_rdata=0x80FF_0000, ack after 3 BUSY cycles -> o_mem_addr=0x100, o_stall high for 4 cycles, then wb_data=0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
REQ-024 SH at addr 0x202, wdata=0x1234_ABCD -> bmask=4'b1100, o_mem_wdata=0xABCD_ABCD, o_mem_we=1, no o_wb_valid.
REQ-025 LW at addr 0x006: with MISALIGN_TRAP_EN -> no o_mem_req, o_misalign pulse; without it -> access at 0x004, full word returned.
REQ-026 i_rst asserted in the 2nd BUSY cycle with ack the cycle after -> o_mem_req drops, no o_wb_valid, FSM IDLE, and the next op is accepted normally.
